// File: rtl/user_rc_cpl_parser.sv
// Requester-completion stream parser: unpacks completion TLPs into
// tag-addressed buffer writes and reports per-TLP completion status.
module user_rc_cpl_parser #(
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RC_TUSER_WIDTH = 75,
    parameter int TAG_WIDTH           = 5
) (
    input  logic                           user_clk,
    input  logic                           user_reset,
    input  logic [C_DATA_WIDTH-1:0]        s_axis_rc_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_rc_tkeep,
    input  logic                           s_axis_rc_tlast,
    input  logic                           s_axis_rc_tvalid,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0] s_axis_rc_tuser,
    output logic                           buf_wr_en,
    output logic [TAG_WIDTH+9:0]           buf_wr_addr,
    output logic [C_DATA_WIDTH-1:0]        buf_wr_data,
    output logic [KEEP_WIDTH-1:0]          buf_wr_dw_en,
    output logic                           cpl_done,
    output logic [TAG_WIDTH-1:0]           cpl_tag,
    output logic [2:0]                     cpl_status,
    output logic [3:0]                     cpl_err_code,
    output logic                           cpl_ok,
    output logic                           cpl_final,
    output logic                           err_len,
    output logic [31:0]                    cpl_count,
    output logic [15:0]                    err_count
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD} state_t;

    state_t               state, state_nx;
    logic [TAG_WIDTH-1:0] tag_r, tag_nx;
    logic [2:0]           status_r, status_nx;
    logic [3:0]           code_r, code_nx;
    logic                 final_r, final_nx;
    logic                 good_r, good_nx;
    logic                 lerr_r, lerr_nx;
    logic [9:0]           offset, offset_nx;
    logic [10:0]          remaining, rem_nx;

    logic                    wr_en_nx;
    logic [TAG_WIDTH+9:0]    wr_addr_nx;
    logic [C_DATA_WIDTH-1:0] wr_data_nx;
    logic [KEEP_WIDTH-1:0]   dw_en_nx;

    logic                 ev, ev_ok, ev_lerr;
    logic [TAG_WIDTH-1:0] ev_tag;
    logic [2:0]           ev_status;
    logic [3:0]           ev_code;
    logic                 ev_final;

    logic [11:0]          d_lower;
    logic [10:0]          d_dwc;
    logic [TAG_WIDTH-1:0] d_tag;
    logic                 d_good, first;
    logic [10:0]          n_dw, take;

    // Sideband carries nothing this parser needs.
    logic unused_ok;
    assign unused_ok = ^s_axis_rc_tuser;

    assign d_lower = s_axis_rc_tdata[11:0];
    assign d_dwc   = s_axis_rc_tdata[42:32];
    assign d_tag   = s_axis_rc_tdata[64 +: TAG_WIDTH];
    assign d_good  = (s_axis_rc_tdata[45:43] == 3'd0)
                  && (s_axis_rc_tdata[15:12] == 4'd0)
                  && !s_axis_rc_tdata[46];
    assign first   = d_good && (d_dwc != 11'd0) && s_axis_rc_tkeep[3];

    // Beat decode: next state, write strobe/lanes and completion event.
    always_comb begin
        state_nx   = state;
        tag_nx     = tag_r;
        status_nx  = status_r;
        code_nx    = code_r;
        final_nx   = final_r;
        good_nx    = good_r;
        lerr_nx    = lerr_r;
        offset_nx  = offset;
        rem_nx     = remaining;
        wr_en_nx   = 1'b0;
        dw_en_nx   = '0;
        wr_addr_nx = buf_wr_addr;
        wr_data_nx = buf_wr_data;
        ev         = 1'b0;
        ev_lerr    = 1'b0;
        n_dw       = '0;
        for (int i = 0; i < KEEP_WIDTH; i++)
            n_dw = n_dw + 11'(s_axis_rc_tkeep[i]);
        take = (n_dw > remaining) ? remaining : n_dw;
        if (s_axis_rc_tvalid) begin
            unique case (state)
                IDLE: begin
                    tag_nx    = d_tag;
                    status_nx = s_axis_rc_tdata[45:43];
                    code_nx   = s_axis_rc_tdata[15:12];
                    final_nx  = s_axis_rc_tdata[30];
                    good_nx   = d_good;
                    offset_nx = d_lower[11:2] + {9'd0, first};
                    rem_nx    = d_dwc - {10'd0, first};
                    lerr_nx   = d_good && s_axis_rc_tkeep[3]
                             && (d_dwc == 11'd0);
                    if (first) begin
                        wr_en_nx         = 1'b1;
                        dw_en_nx[0]      = 1'b1;
                        wr_addr_nx       = {d_tag, d_lower[11:2]};
                        wr_data_nx       = '0;
                        wr_data_nx[31:0] = s_axis_rc_tdata[127:96];
                    end
                    if (s_axis_rc_tlast) begin
                        ev      = 1'b1;
                        ev_lerr = lerr_nx || (d_good && rem_nx != 11'd0);
                    end else begin
                        state_nx = d_good ? PAYLOAD : DISCARD;
                    end
                end
                PAYLOAD: begin
                    for (int i = 0; i < KEEP_WIDTH; i++)
                        dw_en_nx[i] = s_axis_rc_tkeep[i] && (11'(i) < take);
                    if (take != 11'd0) begin
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = {tag_r, offset};
                        wr_data_nx = s_axis_rc_tdata;
                    end
                    offset_nx = offset + n_dw[9:0];
                    rem_nx    = remaining - take;
                    lerr_nx   = lerr_r || (n_dw > remaining);
                    if (s_axis_rc_tlast) begin
                        ev       = 1'b1;
                        ev_lerr  = lerr_nx || (rem_nx != 11'd0);
                        state_nx = IDLE;
                    end
                end
                DISCARD: begin
                    if (s_axis_rc_tlast) begin
                        ev       = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        ev_tag    = tag_nx;
        ev_status = status_nx;
        ev_code   = code_nx;
        ev_final  = final_nx;
        ev_ok     = good_nx && !ev_lerr;
    end

    // Register parser state, write port, completion report and counters.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state        <= IDLE;
            tag_r        <= '0;
            status_r     <= '0;
            code_r       <= '0;
            final_r      <= 1'b0;
            good_r       <= 1'b0;
            lerr_r       <= 1'b0;
            offset       <= '0;
            remaining    <= '0;
            buf_wr_en    <= 1'b0;
            buf_wr_addr  <= '0;
            buf_wr_data  <= '0;
            buf_wr_dw_en <= '0;
            cpl_done     <= 1'b0;
            cpl_tag      <= '0;
            cpl_status   <= '0;
            cpl_err_code <= '0;
            cpl_ok       <= 1'b0;
            cpl_final    <= 1'b0;
            err_len      <= 1'b0;
            cpl_count    <= '0;
            err_count    <= '0;
        end else begin
            state        <= state_nx;
            tag_r        <= tag_nx;
            status_r     <= status_nx;
            code_r       <= code_nx;
            final_r      <= final_nx;
            good_r       <= good_nx;
            lerr_r       <= lerr_nx;
            offset       <= offset_nx;
            remaining    <= rem_nx;
            buf_wr_en    <= wr_en_nx;
            buf_wr_addr  <= wr_addr_nx;
            buf_wr_data  <= wr_data_nx;
            buf_wr_dw_en <= dw_en_nx;
            cpl_done     <= ev;
            err_len      <= ev && ev_lerr;
            if (ev) begin
                cpl_tag      <= ev_tag;
                cpl_status   <= ev_status;
                cpl_err_code <= ev_code;
                cpl_ok       <= ev_ok;
                cpl_final    <= ev_final;
                cpl_count    <= cpl_count + 32'd1;
                if (!ev_ok && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_user_rc_cpl_parser.sv
// Bench for user_rc_cpl_parser: table of single-beat TLPs plus
// multi-beat sequences, checked by write and completion scoreboards.
module tb_user_rc_cpl_parser;

    logic         user_clk = 1'b0;
    logic         user_reset = 1'b1;
    logic [127:0] s_axis_rc_tdata = '0;
    logic [3:0]   s_axis_rc_tkeep = '0;
    logic         s_axis_rc_tlast = 1'b0;
    logic         s_axis_rc_tvalid = 1'b0;
    logic [74:0]  s_axis_rc_tuser = '0;
    logic         buf_wr_en;
    logic [14:0]  buf_wr_addr;
    logic [127:0] buf_wr_data;
    logic [3:0]   buf_wr_dw_en;
    logic         cpl_done;
    logic [4:0]   cpl_tag;
    logic [2:0]   cpl_status;
    logic [3:0]   cpl_err_code;
    logic         cpl_ok;
    logic         cpl_final;
    logic         err_len;
    logic [31:0]  cpl_count;
    logic [15:0]  err_count;

    user_rc_cpl_parser dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .s_axis_rc_tdata(s_axis_rc_tdata), .s_axis_rc_tkeep(s_axis_rc_tkeep),
        .s_axis_rc_tlast(s_axis_rc_tlast), .s_axis_rc_tvalid(s_axis_rc_tvalid),
        .s_axis_rc_tuser(s_axis_rc_tuser),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .buf_wr_dw_en(buf_wr_dw_en),
        .cpl_done(cpl_done), .cpl_tag(cpl_tag), .cpl_status(cpl_status),
        .cpl_err_code(cpl_err_code), .cpl_ok(cpl_ok), .cpl_final(cpl_final),
        .err_len(err_len), .cpl_count(cpl_count), .err_count(err_count)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [14:0]  addr;
        logic [3:0]   dwen;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic [4:0] tag;
        logic [2:0] st;
        logic [3:0] ec;
        logic       ok;
        logic       fin;
        logic       lerr;
    } cpl_t;

    typedef struct {
        logic [4:0]  tag;
        logic [11:0] lower;
        logic [10:0] dwc;
        logic [2:0]  st;
        logic [3:0]  ec;
        logic        po;
        logic        fin;
        logic [3:0]  keep;
        logic [31:0] p0;
        logic        wr;
        logic [14:0] addr;
        logic        ok;
        logic        lerr;
    } vec_t;

    wr_t  wq[$];
    cpl_t cq[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    int   exp_errs = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] desc(
        input logic [4:0] tag, input logic [11:0] lower,
        input logic [10:0] dwc, input logic [2:0] st, input logic [3:0] ec,
        input logic po, input logic fin, input logic [31:0] p0);
        logic [127:0] d;
        d = '0;
        d[11:0]   = lower;
        d[15:12]  = ec;
        d[28:16]  = {dwc, 2'b00};
        d[30]     = fin;
        d[42:32]  = dwc;
        d[45:43]  = st;
        d[46]     = po;
        d[71:64]  = {3'b000, tag};
        d[127:96] = p0;
        return d;
    endfunction

    task automatic push_wr(input logic [4:0] tag, input logic [9:0] off,
                           input logic [3:0] dwen, input logic [127:0] data);
        wr_t w;
        w.addr = {tag, off};
        w.dwen = dwen;
        w.data = data;
        wq.push_back(w);
    endtask

    task automatic push_cpl(input logic [4:0] tag, input logic [2:0] st,
                            input logic [3:0] ec, input logic ok,
                            input logic fin, input logic lerr);
        cpl_t c;
        c.tag = tag; c.st = st; c.ec = ec;
        c.ok = ok; c.fin = fin; c.lerr = lerr;
        cq.push_back(c);
    endtask

    task automatic beat(input logic [127:0] d, input logic [3:0] k,
                        input logic l);
        @(negedge user_clk);
        s_axis_rc_tdata  = d;
        s_axis_rc_tkeep  = k;
        s_axis_rc_tlast  = l;
        s_axis_rc_tvalid = 1'b1;
    endtask

    task automatic idle();
        @(negedge user_clk);
        s_axis_rc_tvalid = 1'b0;
        s_axis_rc_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (wq.size() != 0 || cq.size() != 0); i++)
            @(negedge user_clk);
        chk("wr_queue_drained", 128'(wq.size()), 128'd0);
        chk("cpl_queue_drained", 128'(cq.size()), 128'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 128'(buf_wr_en), 128'd0);
        chk({tag, "_wr_addr"}, 128'(buf_wr_addr), 128'd0);
        chk({tag, "_wr_data"}, buf_wr_data, 128'd0);
        chk({tag, "_dw_en"}, 128'(buf_wr_dw_en), 128'd0);
        chk({tag, "_cpl"}, 128'({cpl_done, cpl_tag, cpl_status,
            cpl_err_code, cpl_ok, cpl_final, err_len}), 128'd0);
        chk({tag, "_cpl_count"}, 128'(cpl_count), 128'd0);
        chk({tag, "_err_count"}, 128'(err_count), 128'd0);
    endtask

    // Scoreboard monitor, sampled 1 time unit after each rising edge.
    always @(posedge user_clk) begin
        #1;
        if (!user_reset) begin
            if (buf_wr_en) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h", buf_wr_addr);
                end else begin
                    wr_t w;
                    logic [127:0] m;
                    w = wq.pop_front();
                    for (int i = 0; i < 4; i++)
                        m[32*i +: 32] = {32{w.dwen[i]}};
                    chk("wr_addr", 128'(buf_wr_addr), 128'(w.addr));
                    chk("wr_dw_en", 128'(buf_wr_dw_en), 128'(w.dwen));
                    chk("wr_data", buf_wr_data & m, w.data & m);
                end
            end else begin
                chk("idle_dw_en", 128'(buf_wr_dw_en), 128'd0);
            end
            if (cpl_done) begin
                if (cq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_cpl: tag %0h", cpl_tag);
                end else begin
                    cpl_t c;
                    c = cq.pop_front();
                    exp_cnt++;
                    if (!c.ok) exp_errs++;
                    chk("cpl_tag", 128'(cpl_tag), 128'(c.tag));
                    chk("cpl_status", 128'(cpl_status), 128'(c.st));
                    chk("cpl_err_code", 128'(cpl_err_code), 128'(c.ec));
                    chk("cpl_ok", 128'(cpl_ok), 128'(c.ok));
                    chk("cpl_final", 128'(cpl_final), 128'(c.fin));
                    chk("err_len", 128'(err_len), 128'(c.lerr));
                    chk("cpl_count", 128'(cpl_count), 128'(exp_cnt));
                    chk("err_count", 128'(err_count), 128'(exp_errs));
                end
            end else begin
                chk("err_len_idle", 128'(err_len), 128'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{5'd3, 12'h010, 11'd1, 3'd0, 4'd0, 1'b0, 1'b0, 4'b1111,
                  32'hA5A5A5A5, 1'b1, 15'h0C04, 1'b1, 1'b0};
        vt[1] = '{5'd9, 12'h000, 11'd0, 3'd1, 4'd0, 1'b0, 1'b0, 4'b0111,
                  32'h0, 1'b0, 15'h0, 1'b0, 1'b0};
        vt[2] = '{5'd10, 12'h040, 11'd1, 3'd0, 4'd0, 1'b1, 1'b0, 4'b1111,
                  32'h11111111, 1'b0, 15'h0, 1'b0, 1'b0};
        vt[3] = '{5'd11, 12'h080, 11'd1, 3'd0, 4'd5, 1'b0, 1'b1, 4'b1111,
                  32'h22222222, 1'b0, 15'h0, 1'b0, 1'b0};
        vt[4] = '{5'd12, 12'h0C8, 11'd2, 3'd0, 4'd0, 1'b0, 1'b0, 4'b1111,
                  32'h33333333, 1'b1, 15'h3032, 1'b0, 1'b1};
        vt[5] = '{5'd13, 12'h004, 11'd1, 3'd0, 4'd0, 1'b0, 1'b0, 4'b0111,
                  32'h44444444, 1'b0, 15'h0, 1'b0, 1'b1};
        vt[6] = '{5'd31, 12'hFFC, 11'd0, 3'd0, 4'd0, 1'b0, 1'b1, 4'b0111,
                  32'h0, 1'b0, 15'h0, 1'b1, 1'b0};

        repeat (3) @(negedge user_clk);
        chk_zero("reset");
        @(negedge user_clk);
        user_reset = 1'b0;

        // Single-beat TLPs, back to back.
        for (int i = 0; i < 7; i++) begin
            if (vt[i].wr) begin
                wr_t w;
                w.addr = vt[i].addr;
                w.dwen = 4'b0001;
                w.data = {96'd0, vt[i].p0};
                wq.push_back(w);
            end
            push_cpl(vt[i].tag, vt[i].st, vt[i].ec, vt[i].ok, vt[i].fin,
                     vt[i].lerr);
            beat(desc(vt[i].tag, vt[i].lower, vt[i].dwc, vt[i].st,
                      vt[i].ec, vt[i].po, vt[i].fin, vt[i].p0),
                 vt[i].keep, 1'b1);
        end
        idle();
        drain();

        // Three-beat TLP, 8 dwords, with a gap mid-TLP.
        push_wr(5'd1, 10'd0, 4'b0001, {96'd0, 32'hD0});
        beat(desc(5'd1, 12'h000, 11'd8, 3'd0, 4'd0, 1'b0, 1'b0, 32'hD0),
             4'b1111, 1'b0);
        push_wr(5'd1, 10'd1, 4'b1111, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
        beat({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 4'b1111, 1'b0);
        idle();
        push_wr(5'd1, 10'd5, 4'b0111, {32'hDEAD, 32'hD7, 32'hD6, 32'hD5});
        push_cpl(5'd1, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        beat({32'hDEAD, 32'hD7, 32'hD6, 32'hD5}, 4'b0111, 1'b1);

        // Short TLP: tlast after 5 of 8 dwords.
        push_wr(5'd2, 10'h040, 4'b0001, {96'd0, 32'hE0});
        beat(desc(5'd2, 12'h100, 11'd8, 3'd0, 4'd0, 1'b0, 1'b0, 32'hE0),
             4'b1111, 1'b0);
        push_wr(5'd2, 10'h041, 4'b1111, {32'hE4, 32'hE3, 32'hE2, 32'hE1});
        push_cpl(5'd2, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        beat({32'hE4, 32'hE3, 32'hE2, 32'hE1}, 4'b1111, 1'b1);

        // Overlong beat: only the remaining two dwords are written.
        push_wr(5'd4, 10'd0, 4'b0001, {96'd0, 32'hF0});
        beat(desc(5'd4, 12'h000, 11'd3, 3'd0, 4'd0, 1'b0, 1'b0, 32'hF0),
             4'b1111, 1'b0);
        push_wr(5'd4, 10'd1, 4'b0011, {32'hF4, 32'hF3, 32'hF2, 32'hF1});
        push_cpl(5'd4, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        beat({32'hF4, 32'hF3, 32'hF2, 32'hF1}, 4'b1111, 1'b1);

        // Offset wraps from 0x3FF to 0x000.
        push_wr(5'd5, 10'h3FF, 4'b0001, {96'd0, 32'hC0});
        beat(desc(5'd5, 12'hFFC, 11'd2, 3'd0, 4'd0, 1'b0, 1'b0, 32'hC0),
             4'b1111, 1'b0);
        push_wr(5'd5, 10'h000, 4'b0001, {96'd0, 32'hC1});
        push_cpl(5'd5, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        beat({96'd0, 32'hC1}, 4'b0001, 1'b1);

        // Bad status over two beats: discarded, no writes.
        beat(desc(5'd6, 12'h000, 11'd4, 3'd2, 4'd0, 1'b0, 1'b0, 32'h0),
             4'b0111, 1'b0);
        push_cpl(5'd6, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        beat({32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111, 1'b1);
        idle();
        drain();

        // Reset in the middle of an 8-dword TLP.
        push_wr(5'd6, 10'd0, 4'b0001, {96'd0, 32'hB0});
        beat(desc(5'd6, 12'h000, 11'd8, 3'd0, 4'd0, 1'b0, 1'b0, 32'hB0),
             4'b1111, 1'b0);
        push_wr(5'd6, 10'd1, 4'b1111, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
        beat({32'hB4, 32'hB3, 32'hB2, 32'hB1}, 4'b1111, 1'b0);
        @(negedge user_clk);
        s_axis_rc_tvalid = 1'b0;
        user_reset = 1'b1;
        #1;
        chk_zero("midrst");
        exp_cnt = 0;
        exp_errs = 0;
        repeat (2) @(negedge user_clk);
        user_reset = 1'b0;
        push_wr(5'd7, 10'h008, 4'b0001, {96'd0, 32'h77777777});
        push_cpl(5'd7, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        beat(desc(5'd7, 12'h020, 11'd1, 3'd0, 4'd0, 1'b0, 1'b0,
                  32'h77777777), 4'b1111, 1'b1);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
